even_parity_serial_tx: RTL and testbench
========================================

Name: even_parity_serial_tx

Overview:
Transmit side for the 4-bit even-parity checker. Accepts a parallel data word over a valid/ready handshake and computes its even-parity bit. Shifts out a fixed serial frame: start bit, data LSB-first, parity bit, stop bit. The far end deserialises the frame and feeds data plus parity to the even-parity checker, which must report 0 for every error-free frame.

Parameters:
DATA_W, 4, data word width in bits (frame carries DATA_W data bits)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  DATA_W  parallel data word to transmit
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
par_out  output  1  even-parity bit of the word currently or last latched
frame_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values after an rst edge:
  - state=IDLE, tx=1, busy=0, par_out=0, frame_done=0.
  - Shift register and bit/clock counters = 0.
  - din_ready=1.
- din_ready = (state==IDLE) && !rst. It is combinational from state.
- Accept occurs on an edge where din_valid && din_ready. At that edge:
  - din is latched into the shift register.
  - par_out <= XOR of all din bits. The ones count of {din, par_out} is then always even.
  - state <= START.
- din and din_valid are ignored outside IDLE. The latched word is unaffected by din changes mid-frame.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Each of START, PARITY and STOP lasts exactly CLKS_PER_BIT cycles.
  - DATA lasts DATA_W*CLKS_PER_BIT cycles.
  - A clock-divider counter runs 0..CLKS_PER_BIT-1 and wraps. A bit index runs 0..DATA_W-1 in DATA.
- tx is registered:
  - START drives tx=0.
  - DATA drives tx=data[bit_index], LSB first.
  - PARITY drives tx=par_out.
  - STOP and IDLE drive tx=1.
- Latency: for an accept at edge k, tx=0 from the cycle after edge k. Frame length on tx = (DATA_W+3)*CLKS_PER_BIT cycles.
- busy=1 from the cycle after accept through the last STOP cycle. busy=0 in IDLE.
- frame_done=1 only on the last cycle of STOP. The next edge returns to IDLE. This gives at least one IDLE cycle between back-to-back frames, with tx=1 in that cycle.
- If din_valid is held continuously, a new word is accepted on the first IDLE cycle.
- Reset mid-frame: abort immediately.
  - Next cycle: tx=1, busy=0, no frame_done pulse.
  - The partially sent frame is not resumed.
- rst has priority over an accept in the same cycle.
- CLKS_PER_BIT=1 must work: one cycle per bit, with no off-by-one in the counter wrap.
- par_out holds its value after the frame ends until the next accept.

Test Plan:
- Reset, then din=4'b1011 with din_valid for one cycle, CLKS_PER_BIT=4 -> par_out=1. tx sequence, each bit for 4 cycles: 0,1,1,0,1,1,1. That is 28 cycles, with frame_done on cycle 28 and din_ready=1 on cycle 29.
- din=4'b0000 and din=4'b1111 -> par_out=0 for both. Data bits on tx are all 0 and all 1 respectively; parity bit is 0 in both frames.
- Exhaustive loopback: all 16 din values. A bench deserialiser samples mid-bit and feeds {data, parity} to the 4-bit even-parity checker -> checker output 0 for every frame, and received data equals din.
- Hold din_valid=1 with din=4'b0110, then change din to 4'b1001 mid-frame -> first frame carries 0110. din_ready stays 0 while busy. The second frame (1001, parity 0) starts after exactly one idle cycle with tx=1.
- Assert rst for one cycle during DATA (bit 2) of din=4'b0101 -> next cycle tx=1, busy=0, din_ready=1, no frame_done. A fresh accept then produces a complete correct frame.
- CLKS_PER_BIT=1, din=4'b1110 -> 7-cycle frame 0,0,1,1,1,1,1 and frame_done on cycle 7.

Source files
------------

// File: rtl/even_parity_serial_tx.sv
// Serial transmitter: latches a word over valid/ready, computes its even-parity bit,
// and sends start, data (LSB first), parity and stop bits, each held CLKS_PER_BIT cycles.
module even_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              par_out,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Handshake: a word is taken on any rising edge where din_valid && din_ready,
    // and din_ready is high only in IDLE while rst is low.
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              cnt_last;
    logic [DATA_W-1:0] shifted;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign shifted  = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line value for the cycle after this edge, so tx is a clean flop output.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                tx_d  = 1'b1;
                if (din_valid) begin
                    shift_d = din;
                    par_d   = ^din;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                        idx_d   = '0;
                        tx_d    = par_q;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shifted;
                        tx_d    = shifted[0];
                    end
                end
            end
            S_PARITY: begin
                if (cnt_last) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign din_ready  = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && cnt_last;
    assign tx         = tx_q;
    assign par_out    = par_q;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: frame-level reference model, bench deserialiser and
// even-parity checker, with one DUT at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1.
module tb_even_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [3:0] din;

    logic rdy4, tx4, busy4, par4, fd4;
    logic rdy1, tx1, busy1, par1, fd1;
    logic rdy_m, tx_m, busy_m, par_m, fd_m;
    logic sel = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy4),
        .tx(tx4), .busy(busy4), .par_out(par4), .frame_done(fd4)
    );

    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1),
        .tx(tx1), .busy(busy1), .par_out(par1), .frame_done(fd1)
    );

    always_comb begin
        rdy_m  = sel ? rdy1  : rdy4;
        tx_m   = sel ? tx1   : tx4;
        busy_m = sel ? busy1 : busy4;
        par_m  = sel ? par1  : par4;
        fd_m   = sel ? fd1   : fd4;
    end

    // Called at a negedge in an IDLE cycle; returns at the negedge of the first frame cycle.
    task automatic accept(input logic [3:0] word, input bit hold);
        din       = word;
        din_valid = 1'b1;
        #1;
        checks++;
        if (rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready word=%h got=%b exp=1", word, rdy_m);
        end
        exp_q.push_back(word);
        @(negedge clk);
        if (!hold) din_valid = 1'b0;
        checks++;
        if (par_m !== ^word) begin
            errors++;
            $display("FAIL par_out word=%h got=%b exp=%b", word, par_m, ^word);
        end
    endtask

    // Follows one whole frame from its first cycle, then checks the idle cycle after it.
    task automatic watch_frame(input logic [3:0] word, input int cpb,
                               output logic [3:0] rx, output logic rx_par);
        logic [6:0] bits;
        logic [6:0] rxbits;
        int n;
        bits   = {1'b1, ^word, word, 1'b0};
        rxbits = '0;
        n      = 7 * cpb;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (tx_m !== bits[c / cpb]) begin
                errors++;
                $display("FAIL tx word=%h cpb=%0d cycle=%0d got=%b exp=%b",
                         word, cpb, c + 1, tx_m, bits[c / cpb]);
            end
            checks++;
            if ({busy_m, rdy_m, fd_m} !== {1'b1, 1'b0, (c == n - 1)}) begin
                errors++;
                $display("FAIL frame_status word=%h cycle=%0d busy/ready/done got=%b%b%b exp=10%b",
                         word, c + 1, busy_m, rdy_m, fd_m, (c == n - 1));
            end
            if ((c % cpb) == (cpb / 2)) rxbits[c / cpb] = tx_m;
            @(negedge clk);
        end
        #1;
        checks++;
        if ({tx_m, busy_m, rdy_m, fd_m} !== 4'b1010) begin
            errors++;
            $display("FAIL idle_after tx/busy/ready/done got=%b%b%b%b exp=1010",
                     tx_m, busy_m, rdy_m, fd_m);
        end
        checks++;
        if (par_m !== ^word) begin
            errors++;
            $display("FAIL par_hold word=%h got=%b exp=%b", word, par_m, ^word);
        end
        rx     = rxbits[4:1];
        rx_par = rxbits[5];
    endtask

    task automatic score(input logic [3:0] rx, input logic rx_par);
        logic [3:0] exp_w;
        exp_w = exp_q.pop_front();
        checks++;
        if (rx !== exp_w) begin
            errors++;
            $display("FAIL rx_data got=%h exp=%h", rx, exp_w);
        end
        checks++;
        if ((^{rx, rx_par}) !== 1'b0) begin
            errors++;
            $display("FAIL parity_checker data=%h par=%b got=1 exp=0", rx, rx_par);
        end
    endtask

    task automatic send(input logic [3:0] word, input int cpb);
        logic [3:0] rx;
        logic       rx_par;
        accept(word, 1'b0);
        watch_frame(word, cpb, rx, rx_par);
        score(rx, rx_par);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        din       = 4'hF;
        din_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({tx_m, busy_m, rdy_m, par_m, fd_m} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_held tx/busy/ready/par/done got=%b%b%b%b%b exp=10000",
                     tx_m, busy_m, rdy_m, par_m, fd_m);
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        #1;
        checks++;
        if ({tx_m, busy_m, rdy_m, par_m, fd_m} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_release tx/busy/ready/par/done got=%b%b%b%b%b exp=10100",
                     tx_m, busy_m, rdy_m, par_m, fd_m);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_words;
        send(4'b1011, 4);
        send(4'b0000, 4);
        send(4'b1111, 4);
    endtask

    task automatic test_loopback;
        logic [3:0] vals[16];
        logic [3:0] tmp;
        int j;
        for (int i = 0; i < 16; i++) vals[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            j       = $urandom_range(i, 0);
            tmp     = vals[i];
            vals[i] = vals[j];
            vals[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            send(vals[i], 4);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] rx;
        logic       rx_par;
        accept(4'b0110, 1'b1);
        din = 4'b1001;
        watch_frame(4'b0110, 4, rx, rx_par);
        score(rx, rx_par);
        exp_q.push_back(4'b1001);
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if (par_m !== 1'b0) begin
            errors++;
            $display("FAIL b2b_par got=%b exp=0", par_m);
        end
        watch_frame(4'b1001, 4, rx, rx_par);
        score(rx, rx_par);
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] dropped;
        accept(4'b0101, 1'b0);
        repeat (13) @(negedge clk);
        checks++;
        if (tx_m !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_bit2 got=%b exp=1", tx_m);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_m, busy_m, rdy_m, fd_m} !== 4'b1010) begin
            errors++;
            $display("FAIL abort tx/busy/ready/done got=%b%b%b%b exp=1010",
                     tx_m, busy_m, rdy_m, fd_m);
        end
        dropped = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if ({tx_m, busy_m, fd_m} !== 3'b100) begin
            errors++;
            $display("FAIL abort_stays_idle word=%h tx/busy/done got=%b%b%b exp=100",
                     dropped, tx_m, busy_m, fd_m);
        end
        send(4'($urandom_range(15, 0)), 4);
    endtask

    task automatic test_cpb1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        @(negedge clk);
        send(4'b1110, 1);
        for (int i = 0; i < 4; i++) send(4'($urandom_range(15, 0)), 1);
    endtask

    initial begin
        din_valid = 1'b0;
        din       = '0;
        rst       = 1'b1;
        test_reset();
        test_fixed_words();
        test_loopback();
        test_back_to_back();
        test_reset_mid_frame();
        test_cpb1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
